// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the execute-stage multiply/divide unit.
//   - MDU op encoding carried in the MDU op field of ControlSignal_E
//   - position of that field within ControlSignal_E
//   - FSM state encoding used by mdu_ex
package mdu_pkg;

    localparam int MDU_OP_W = 3;

    // MDU op field location inside the ID/EX ControlSignal_E bundle.
    localparam int CS_MDU_OP_LSB = 0;
    localparam int CS_MDU_OP_MSB = CS_MDU_OP_LSB + MDU_OP_W - 1;

    // Encodings 6 and 7 are reserved and have no effect.
    typedef enum logic [MDU_OP_W-1:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_iter.sv
// mdu_div_iter: iterative restoring divider core, one quotient bit per step.
// Operates on magnitudes only; sign handling lives in the parent.
//   clk, reset        : clock, asynchronous active-high reset
//   load              : capture dividend/divisor and the iteration count
//   step              : perform one restoring iteration
//   dividend, divisor : unsigned operands (sampled on load)
//   iters             : iterations to run (1..WIDTH); the dividend is pre-shifted
//                       so the skipped leading iterations would only yield zeros
//   last              : the step taken this cycle is the final one
//   quot, rem         : quotient and remainder magnitudes
module mdu_div_iter #(
    parameter int WIDTH = 32,
    parameter int IW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [IW-1:0]    iters,
    output logic             last,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);
    logic [WIDTH-1:0] q_q, q_d;   // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [IW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0] r_trial;
    logic [WIDTH:0] diff;

    // Partial remainder stays below the divisor, so the trial value minus the
    // divisor fits in WIDTH+1 bits and its MSB is a valid sign.
    assign r_trial = {r_q, q_q[WIDTH-1]};
    assign diff    = r_trial - {1'b0, d_q};

    always_comb begin
        q_d   = q_q;
        r_d   = r_q;
        d_d   = d_q;
        cnt_d = cnt_q;
        if (load) begin
            q_d   = dividend << (IW'(WIDTH) - iters);
            r_d   = '0;
            d_d   = divisor;
            cnt_d = iters;
        end else if (step) begin
            if (!diff[WIDTH]) begin
                r_d = diff[WIDTH-1:0];
                q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
                r_d = r_trial[WIDTH-1:0];
                q_d = {q_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q   <= '0;
            r_q   <= '0;
            d_q   <= '0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            r_q   <= r_d;
            d_q   <= d_d;
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == IW'(1));
    assign quot = q_q;
    assign rem  = r_q;

endmodule

// File: rtl/mdu_ex.sv
// mdu_ex: execute-stage multiply/divide unit with HI/LO registers.
//   clk, reset   : clock, asynchronous active-high reset
//   start, op    : request from ID/EX (op per mdu_pkg::mdu_op_e), sampled when idle
//   src_a, src_b : rs / rt operand values
//   flush        : squash the in-flight operation (and any same-cycle start)
//   busy         : operation in flight, stalls MDU ops and MFHI/MFLO
//   done         : one-cycle pulse when HI/LO take a multiply/divide result
//   hi, lo       : architectural HI/LO registers
// Build option: define MDU_DIV_EARLY_EXIT_EN to let the divider skip the
// leading-zero iterations of the dividend magnitude (results unchanged).
module mdu_ex
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    src_a,
    input  logic [WIDTH-1:0]    src_b,
    input  logic                flush,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    hi,
    output logic [WIDTH-1:0]    lo
);
    localparam int CW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
    localparam int IW = $clog2(WIDTH + 1);

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             sgn_q, sgn_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d;
    logic             fix_q, fix_d;
    logic             done_q, done_d;

    mdu_op_e            op_e;
    logic               signed_div;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic               div_load, div_step, div_last;
    logic [IW-1:0]      div_iters;
    logic [WIDTH-1:0]   div_quot, div_rem;

    assign op_e       = mdu_op_e'(op);
    assign signed_div = (op_e == MDU_DIV);
    assign mag_a      = (signed_div && src_a[WIDTH-1]) ? -src_a : src_a;
    assign mag_b      = (signed_div && src_b[WIDTH-1]) ? -src_b : src_b;

    // Extending both operands to 2*WIDTH makes the low half of an unsigned
    // product equal to the signed product when sign-extended.
    assign ext_a = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign ext_b = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign prod  = ext_a * ext_b;

`ifdef MDU_DIV_EARLY_EXIT_EN
    // Iterations = bit length of the dividend magnitude (at least one).
    // Divide-by-zero keeps the full run so its all-ones quotient is produced.
    always_comb begin
        div_iters = IW'(WIDTH);
        if (mag_b != '0) begin
            div_iters = IW'(1);
            for (int i = 0; i < WIDTH; i++) begin
                if (mag_a[i]) div_iters = IW'(i + 1);
            end
        end
    end
`else
    assign div_iters = IW'(WIDTH);
`endif

    mdu_div_iter #(.WIDTH(WIDTH), .IW(IW)) u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load),
        .step     (div_step),
        .dividend (mag_a),
        .divisor  (mag_b),
        .iters    (div_iters),
        .last     (div_last),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        sgn_d    = sgn_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        fix_d    = fix_q;
        done_d   = 1'b0;
        div_load = 1'b0;
        div_step = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (op_e)
                        MDU_MULT, MDU_MULTU: begin
                            state_d = ST_MUL;
                            cnt_d   = CW'(MULT_CYCLES - 1);
                            a_d     = src_a;
                            b_d     = src_b;
                            sgn_d   = (op_e == MDU_MULT);
                        end
                        MDU_DIV, MDU_DIVU: begin
                            state_d  = ST_DIV;
                            div_load = 1'b1;
                            fix_d    = 1'b0;
                            qneg_d   = signed_div && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                            rneg_d   = signed_div && src_a[WIDTH-1];
                        end
                        MDU_MTHI: hi_d = src_a;
                        MDU_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    {hi_d, lo_d} = prod;
                    done_d       = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DIV: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (fix_q) begin
                    // Sign fix-up cycle after the final iteration.
                    hi_d    = rneg_q ? -div_rem  : div_rem;
                    lo_d    = qneg_q ? -div_quot : div_quot;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    div_step = 1'b1;
                    if (div_last) fix_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            fix_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            fix_q   <= fix_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ex.sv
// tb_mdu_ex: directed + randomized checks of mdu_ex against a behavioural model
// built on 64-bit integer arithmetic.
module tb_mdu_ex;
    localparam int W  = 32;
    localparam int MC = 4;
    localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2,
                           OP_DIVU = 3'd3, OP_MTHI = 3'd4, OP_MTLO = 3'd5;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [W-1:0]  src_a = '0, src_b = '0;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int checks = 0;
    int failures = 0;

    mdu_ex #(.WIDTH(W), .MULT_CYCLES(MC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, prod, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            OP_MULT: begin sq = sa * sb; return sq; end
            OP_MULTU: begin prod = ua * ub; return prod; end
            OP_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub; ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: begin
                if (b == 0) return {a, (sa < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF};
                sq = sa / sb; sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] m;
        int n;
        if (o == OP_MULT || o == OP_MULTU) return MC;
        m = (o == OP_DIV && a[31]) ? -a : a;
        n = 0;
        while (m != 0) begin n++; m = m >> 1; end
`ifdef MDU_DIV_EARLY_EXIT_EN
        if (b != 0) return ((n < 1) ? 1 : n) + 1;
`endif
        return W + 1;
    endfunction

    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int elat);
        logic [31:0] phi, plo;
        int lat;
        bit held;
        @(negedge clk);
        phi = hi; plo = lo;
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ".busy"}, busy, 1);
        lat = 0; held = 1;
        while (!done && lat < 200) begin
            if (hi !== phi || lo !== plo) held = 0;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".lat"}, lat, elat);
        chk({tag, ".held"}, held, 1);
        chk({tag, ".hi"}, hi, ehi);
        chk({tag, ".lo"}, lo, elo);
        chk({tag, ".busy_at_done"}, busy, 0);
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, done, 0);
    endtask

    initial begin
        logic [31:0] phi, plo, a, b;
        logic [2:0]  o;
        logic [63:0] r;
        bit seen;

        // Reset state
        #3;
        chk("rst.hi", hi, 0); chk("rst.lo", lo, 0);
        chk("rst.busy", busy, 0); chk("rst.done", done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed cases
        do_op("mult",  OP_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 4);
        do_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 4);
        do_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
              ref_lat(OP_DIV, 32'hFFFF_FFF9, 32'd2));
        do_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, ref_lat(OP_DIVU, 32'd100, 32'd7));
        do_op("divu0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 33);
        do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
        do_op("divu3_1", OP_DIVU, 32'd3, 32'd1, 32'd0, 32'd3, ref_lat(OP_DIVU, 32'd3, 32'd1));

        // MTHI then MTLO on consecutive cycles
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; src_a = 32'h1234_5678;
        @(negedge clk);
        chk("mthi.hi", hi, 32'h1234_5678); chk("mthi.busy", busy, 0);
        op = OP_MTLO; src_a = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo.lo", lo, 32'h9ABC_DEF0); chk("mtlo.hi", hi, 32'h1234_5678);
        chk("mtlo.busy", busy, 0); chk("mtlo.done", done, 0);

        // Flush mid-divide, with an ignored start while busy
        phi = hi; plo = lo;
        start = 1'b1; op = OP_DIV; src_a = 32'h7FFF_0000; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; src_a = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_start.hi", hi, phi); chk("busy_start.busy", busy, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush.busy", busy, 0); chk("flush.done", done, 0);
        chk("flush.hi", hi, phi); chk("flush.lo", lo, plo);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (done || busy) seen = 1; end
        chk("flush.quiet", seen, 0);

        // Flush wins over a same-cycle start
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = OP_MTHI; src_a = 32'h5555_AAAA;
        @(negedge clk);
        chk("flush_mthi.hi", hi, phi);
        op = OP_MULT;
        @(negedge clk);
        chk("flush_mult.busy", busy, 0);
        start = 1'b0; flush = 1'b0;

        // Reserved op has no effect
        start = 1'b1; op = 3'd6; src_a = 32'hFFFF_0000;
        @(negedge clk);
        start = 1'b0;
        chk("rsvd.busy", busy, 0); chk("rsvd.hi", hi, phi); chk("rsvd.lo", lo, plo);

        // Randomized operations against the model
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom();
            b = $urandom();
            if ($urandom_range(0, 2) == 0) a = $urandom_range(0, 40);
            if ($urandom_range(0, 2) == 0) b = $urandom_range(1, 9);
            if ($urandom_range(0, 3) == 0) a = -a;
            if ($urandom_range(0, 3) == 0) b = -b;
            if ($urandom_range(0, 9) == 0) b = 0;
            r = ref_res(o, a, b);
            do_op($sformatf("rnd%0d_op%0d", i, o), o, a, b, r[63:32], r[31:0], ref_lat(o, a, b));
        end

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; src_a = 32'hCAFE_0001;
        @(negedge clk);
        op = OP_MULT; src_a = 32'd7; src_b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("arst.hi", hi, 0); chk("arst.lo", lo, 0);
        chk("arst.busy", busy, 0); chk("arst.done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        do_op("post_rst_mult", OP_MULT, 32'd7, 32'd9, 32'd0, 32'd63, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_ex.md
Name: mdu_ex

Overview:
- Execute-stage multiply/divide unit with HI/LO registers.
- Consumes reg_read_1E / reg_read_2E and the MDU op field of ControlSignal_E from the ID/EX pipeline register.
- Runs MULT/MULTU/DIV/DIVU as multi-cycle operations and MTHI/MTLO as single-cycle writes.
- Drives busy to the hazard unit, which stalls any MDU op or MFHI/MFLO issued behind it.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 4, multiply latency in cycles from start to done (minimum 1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request qualified by op; sampled only when busy=0.
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6-7 reserved, no effect.
- src_a  in  WIDTH  rs value (dividend / multiplicand / MTHI-MTLO data).
- src_b  in  WIDTH  rt value (divisor / multiplier).
- flush  in  1  cancel the in-flight operation (exception/branch squash).
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse in the cycle HI/LO take a multiply/divide result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: asynchronous, active-high. hi=0, lo=0, busy=0, done=0, FSM=IDLE, counters=0. Asserting reset mid-operation aborts it immediately.
- FSM states: IDLE, MUL, DIV.
- IDLE + start + op 0/1 -> MUL. Operands latched; busy=1 from the next cycle; cycle counter loaded with MULT_CYCLES-1.
- MUL: counter decrements each cycle. At 0, {hi,lo} <= full 2*WIDTH product, done=1, busy falls in the same edge, next state IDLE.
- Start->done latency = MULT_CYCLES cycles.
- MULT is a signed product; MULTU is unsigned.
- IDLE + start + op 2/3 -> DIV. Restoring divider, one quotient bit per cycle, WIDTH iterations, plus one fix-up cycle for signs. Total WIDTH+1 cycles to done.
- DIV: operands are converted to magnitudes. Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a). Result: lo <= quotient, hi <= remainder.
- DIVU: no sign handling.
- Divide by zero: no trap. Result is what the restoring algorithm naturally yields: lo = all ones (DIVU) or sign-adjusted all ones (DIV); hi = dividend. Full duration is still taken.
- Signed overflow (-2^(WIDTH-1) / -1): lo = 0x80000000, hi = 0.
- MTHI/MTLO (op 4/5) with start in IDLE: hi or lo <= src_a on that edge. No busy, no done.
- start while busy=1 is ignored. The hazard unit guarantees no issue; no error flag is raised.
- flush while busy: return to IDLE on the next edge; hi/lo unchanged; done not pulsed.
- flush with start in the same cycle: flush wins; nothing is latched, including MTHI/MTLO.
- hi/lo are readable every cycle. During busy they hold pre-operation values.
- Results write on the done edge, so MFHI/MFLO stalled by busy read the new values after busy falls.

Optional Feature:
- Macro: MDU_DIV_EARLY_EXIT_EN.
- Defined: the divider skips leading iterations using the leading-zero count of the dividend magnitude. Latency becomes (WIDTH - lzc) + 1 cycles, minimum 2. A zero dividend completes in 2 cycles with hi=0, lo=0. Divide-by-zero still takes the full WIDTH+1 cycles.
- Undefined: fixed WIDTH+1 cycle division.
- Results are identical in both builds; only latency differs.

Decomposition:
- Shared package mdu_pkg: op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO), FSM state encoding, MDU_OP_W=3.
- The op field position within ControlSignal_E is also defined in the shared define file.
- One sub-module, mdu_div_iter: iterative restoring divider core with load/step/last handshake, returning quotient and remainder magnitudes.
- Multiply is a behavioural product registered through a MULT_CYCLES-deep delay counter.
- Sign fix-up stays in mdu_ex.

Test Plan:
- MULT src_a=0xFFFFFFFE(-2), src_b=3 -> done exactly 4 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with MULTU -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV src_a=-7 (0xFFFFFFF9), src_b=2 -> done after 33 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo update on each edge; busy stays 0.
- Start DIV, assert flush at cycle 10 -> busy=0 next cycle, hi/lo unchanged, no done. A second start during busy is ignored and hi/lo are unaffected.
- Start MULT, assert reset asynchronously mid-op -> hi=lo=0 and busy=0 immediately. With MDU_DIV_EARLY_EXIT_EN, DIVU 3/1 -> done within 3 cycles, lo=3, hi=0.
